// File: rtl/frame_update_scheduler_if.sv
// rtl/frame_update_scheduler_if.sv - update-slot request/grant handshake between scheduler and engines
interface frame_update_scheduler_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] grant;
    logic               step;

    modport master (
        input  req,
        input  done,
        output grant,
        output step
    );

    modport slave (
        output req,
        output done,
        input  grant,
        input  step
    );
endinterface

// File: rtl/frame_update_scheduler.sv
// rtl/frame_update_scheduler.sv - hands the shared update slot to each requesting engine once per vsync frame
module frame_update_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int COUNT_W        = 16
) (
    input  logic                 Clk_100MHz,
    input  logic                 Reset,
    input  logic                 vsync,
    input  logic                 Game_Enable,
    input  logic                 pauseSwitch,
    input  logic                 clr_err,
    frame_update_scheduler_if.master bus,
    output logic                 frame_done,
    output logic [COUNT_W-1:0]   frame_count,
    output logic                 overrun,
    output logic [NUM_REQ-1:0]   timeout_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, WAIT, FINISH} state_t;

    state_t             state, state_nxt;
    logic               vs_meta, vs_sync, vs_prev, frame_tick;
    logic [NUM_REQ-1:0] pending;
    logic [IW-1:0]      sel, sel_nxt;
    logic [TW-1:0]      timer;
    logic               served, timed_out, start, abort;
    logic [NUM_REQ-1:0] err_set;

    always_ff @(posedge Clk_100MHz or negedge Reset) begin
        if (!Reset) begin
            vs_meta <= 1'b0;
            vs_sync <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            vs_meta <= vsync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    assign frame_tick = vs_sync & ~vs_prev;
    assign start      = frame_tick & Game_Enable & ~pauseSwitch;
    assign abort      = ~Game_Enable;
    assign served     = bus.done[sel];
    assign timed_out  = (timer == TIMER_LAST);

    // Lowest set index wins, so engine 0 always updates first.
    always_comb begin
        sel_nxt = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pending[i]) sel_nxt = IW'(i);
        end
    end

    always_ff @(posedge Clk_100MHz or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        bus.grant  = '0;
        bus.step   = 1'b0;
        frame_done = 1'b0;
        err_set    = '0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SCAN;
            end
            SCAN: begin
                if (abort)             state_nxt = IDLE;
                else if (pending == '0) state_nxt = FINISH;
                else                   state_nxt = WAIT;
            end
            WAIT: begin
                bus.grant = NUM_REQ'(1) << sel;
                bus.step  = (timer == '0);
                if (abort) begin
                    state_nxt = IDLE;
                end else if (served) begin
                    state_nxt = SCAN;
                end else if (timed_out) begin
                    state_nxt = SCAN;
                    err_set   = NUM_REQ'(1) << sel;
                end
            end
            FINISH: begin
                state_nxt  = IDLE;
                frame_done = Game_Enable;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk_100MHz or negedge Reset) begin
        if (!Reset) begin
            pending     <= '0;
            sel         <= '0;
            timer       <= '0;
            frame_count <= '0;
            overrun     <= 1'b0;
            timeout_err <= '0;
        end else begin
            if (state == IDLE && start) pending <= bus.req;
            if (state == SCAN && !abort && pending != '0) begin
                sel              <= sel_nxt;
                pending[sel_nxt] <= 1'b0;
                timer            <= '0;
            end
            if (state == WAIT) timer <= timer + 1'b1;
            if (state != IDLE && abort) pending <= '0;
            if (state == FINISH && Game_Enable) frame_count <= frame_count + 1'b1;
            // A newly raised error takes priority over a simultaneous clear.
            overrun     <= (overrun & ~clr_err) | (frame_tick & (state != IDLE));
            timeout_err <= (timeout_err & ~{NUM_REQ{clr_err}}) | err_set;
        end
    end

endmodule
